// File: rtl/cep_axil_pkg.sv
// Shared FSM state type and AXI response codes for the AXI4-Lite command master.
package cep_axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response port.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a command (cmd_ready_o high once out of reset)
// WR      | AW and/or W still pending; each valid drops after its own handshake
// WR_RESP | waiting for B (b_ready_o high)
// RD_ADDR | AR pending (ar_valid_o high)
// RD_DATA | waiting for R (r_ready_o high)
// RSP     | response presented, held until rsp_ready_i
module axi4lite_cmd_master
  import cep_axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LAT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]              rsp_resp_o,
  output logic [LAT_WIDTH-1:0]    rsp_lat_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic [1:0]              b_resp_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [ADDR_WIDTH-1:0]   ar_addr_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]              r_resp_i
);

  state_t                  state;
  state_t                  state_nxt;
  logic                    init_done;
  logic                    aw_pend;
  logic                    w_pend;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH/8-1:0] strb_reg;
  logic [LAT_WIDTH-1:0]    lat_cnt;
  logic [LAT_WIDTH-1:0]    lat_inc;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic [1:0]              resp_reg;
  logic [LAT_WIDTH-1:0]    lat_reg;

  logic cmd_acc;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic rsp_hs;
  logic busy;

  // cmd_ready is gated by init_done so it stays low through reset and
  // rises on the first clock edge after release.
  assign cmd_ready_o = (state == IDLE) && init_done;
  assign aw_valid_o  = aw_pend;
  assign w_valid_o   = w_pend;
  assign aw_addr_o   = addr_reg;
  assign w_data_o    = wdata_reg;
  assign w_strb_o    = strb_reg;
  assign b_ready_o   = (state == WR_RESP);
  assign ar_valid_o  = (state == RD_ADDR);
  assign ar_addr_o   = addr_reg;
  assign r_ready_o   = (state == RD_DATA);
  assign rsp_valid_o = (state == RSP);
  assign rsp_rdata_o = rdata_reg;
  assign rsp_resp_o  = resp_reg;
  assign rsp_lat_o   = lat_reg;

  assign cmd_acc = cmd_valid_i && cmd_ready_o;
  assign aw_hs   = aw_valid_o && aw_ready_i;
  assign w_hs    = w_valid_o && w_ready_i;
  assign b_hs    = b_valid_i && b_ready_o;
  assign ar_hs   = ar_valid_o && ar_ready_i;
  assign r_hs    = r_valid_i && r_ready_o;
  assign rsp_hs  = rsp_valid_o && rsp_ready_i;
  assign busy    = (state == WR) || (state == WR_RESP) ||
                   (state == RD_ADDR) || (state == RD_DATA);

  // Saturating increment; also the value latched at the B/R handshake so the
  // handshake cycle itself is counted.
  assign lat_inc = (&lat_cnt) ? lat_cnt : lat_cnt + LAT_WIDTH'(1);

  // State register and post-reset ready enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_acc) state_nxt = cmd_we_i ? WR : RD_ADDR;
      end
      WR: begin
        if ((aw_hs || !aw_pend) && (w_hs || !w_pend)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) state_nxt = RSP;
      end
      RD_ADDR: begin
        if (ar_hs) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) state_nxt = RSP;
      end
      RSP: begin
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture and independent AW/W pending flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      strb_reg  <= '0;
      aw_pend   <= 1'b0;
      w_pend    <= 1'b0;
    end else if (cmd_acc) begin
      addr_reg  <= cmd_addr_i;
      wdata_reg <= cmd_wdata_i;
      strb_reg  <= cmd_strb_i;
      aw_pend   <= cmd_we_i;
      w_pend    <= cmd_we_i;
    end else begin
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs)  w_pend  <= 1'b0;
    end
  end

  // Latency counter: cleared on accept, counts busy cycles, saturates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lat_cnt <= '0;
    end else if (cmd_acc) begin
      lat_cnt <= '0;
    end else if (busy) begin
      lat_cnt <= lat_inc;
    end
  end

  // Response capture on the B or R handshake; writes return zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_reg <= '0;
      resp_reg  <= RESP_OKAY;
      lat_reg   <= '0;
    end else if (b_hs) begin
      rdata_reg <= '0;
      resp_reg  <= b_resp_i;
      lat_reg   <= lat_inc;
    end else if (r_hs) begin
      rdata_reg <= r_data_i;
      resp_reg  <= r_resp_i;
      lat_reg   <= lat_inc;
    end
  end

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Directed self-checking bench for axi4lite_cmd_master (default parameters).
module tb_axi4lite_cmd_master;
  import cep_axil_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_lat;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] aw_addr;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_resp;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  int n_vec;
  int n_err;

  axi4lite_cmd_master dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .cmd_strb_i  (cmd_strb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_resp_o  (rsp_resp),
    .rsp_lat_o   (rsp_lat),
    .aw_valid_o  (aw_valid),
    .aw_ready_i  (aw_ready),
    .aw_addr_o   (aw_addr),
    .w_valid_o   (w_valid),
    .w_ready_i   (w_ready),
    .w_data_o    (w_data),
    .w_strb_o    (w_strb),
    .b_valid_i   (b_valid),
    .b_ready_o   (b_ready),
    .b_resp_i    (b_resp),
    .ar_valid_o  (ar_valid),
    .ar_ready_i  (ar_ready),
    .ar_addr_o   (ar_addr),
    .r_valid_i   (r_valid),
    .r_ready_o   (r_ready),
    .r_data_i    (r_data),
    .r_resp_i    (r_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land just after the edge, where outputs are sampled
  // and inputs for the next edge are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_strb  = strb;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic responder_idle();
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    b_resp    = RESP_OKAY;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_data    = '0;
    r_resp    = RESP_OKAY;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    responder_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) step();
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    n_vec++; if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid} !== 6'b0) begin n_err++;
      $display("FAIL reset_handshakes: got %b want 000000", {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid}); end
    n_vec++; if ({rsp_rdata, rsp_resp, rsp_lat, aw_addr} !== 82'h0) begin n_err++;
      $display("FAIL reset_data: rdata %h resp %b lat %h aw_addr %h want all 0", rsp_rdata, rsp_resp, rsp_lat, aw_addr); end
    rst_n = 1'b1;
    step();
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_basic();
    aw_ready = 1'b1; w_ready = 1'b1;
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL wr_idle_ready: got %b want 1", cmd_ready); end
    issue(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    n_vec++; if ({aw_valid, w_valid, b_ready} !== 3'b110) begin n_err++;
      $display("FAIL wr_beat_valids: got aw/w/b %b want 110", {aw_valid, w_valid, b_ready}); end
    n_vec++; if (aw_addr !== 32'h0000_1000 || w_data !== 32'hDEAD_BEEF || w_strb !== 4'hF) begin n_err++;
      $display("FAIL wr_beat_payload: got %h %h %h want 00001000 deadbeef f", aw_addr, w_data, w_strb); end
    step();
    n_vec++; if ({aw_valid, w_valid, b_ready} !== 3'b001) begin n_err++;
      $display("FAIL wr_resp_phase: got aw/w/b %b want 001", {aw_valid, w_valid, b_ready}); end
    aw_ready = 1'b0; w_ready = 1'b0;
    b_valid = 1'b1; b_resp = RESP_OKAY;
    step();
    b_valid = 1'b0;
    n_vec++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin n_err++;
      $display("FAIL wr_rsp: got valid %b resp %b rdata %h want 1 00 0", rsp_valid, rsp_resp, rsp_rdata); end
    n_vec++; if (rsp_lat !== 16'd2) begin n_err++; $display("FAIL wr_lat: got %0d want 2", rsp_lat); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_vec++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_err++;
      $display("FAIL wr_back_idle: got ready %b rsp_valid %b want 1 0", cmd_ready, rsp_valid); end
  endtask

  task automatic test_read_delay();
    ar_ready = 1'b1;
    issue(1'b0, 32'h0000_2004, 32'h0, 4'h0);
    n_vec++; if (ar_valid !== 1'b1 || ar_addr !== 32'h0000_2004 || r_ready !== 1'b0) begin n_err++;
      $display("FAIL rd_ar: got valid %b addr %h r_ready %b want 1 00002004 0", ar_valid, ar_addr, r_ready); end
    step();
    ar_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (r_ready !== 1'b1 || ar_valid !== 1'b0) begin n_err++;
        $display("FAIL rd_wait_%0d: got r_ready %b ar_valid %b want 1 0", i, r_ready, ar_valid); end
      step();
    end
    r_valid = 1'b1; r_data = 32'h1234_5678; r_resp = RESP_OKAY;
    step();
    r_valid = 1'b0;
    n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_resp !== 2'b00) begin n_err++;
      $display("FAIL rd_rsp: got valid %b rdata %h resp %b want 1 12345678 00", rsp_valid, rsp_rdata, rsp_resp); end
    n_vec++; if (rsp_lat !== 16'd7) begin n_err++; $display("FAIL rd_lat: got %0d want 7", rsp_lat); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_write_w_first();
    aw_ready = 1'b0; w_ready = 1'b1;
    issue(1'b1, 32'h0000_3000, 32'hA5A5_5A5A, 4'h3);
    n_vec++; if ({aw_valid, w_valid} !== 2'b11) begin n_err++;
      $display("FAIL wf_start: got aw/w %b want 11", {aw_valid, w_valid}); end
    step();
    w_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({aw_valid, w_valid, b_ready} !== 3'b100 || aw_addr !== 32'h0000_3000) begin n_err++;
        $display("FAIL wf_hold_%0d: got aw/w/b %b addr %h want 100 00003000", i, {aw_valid, w_valid, b_ready}, aw_addr); end
      if (i == 2) aw_ready = 1'b1;
      step();
    end
    aw_ready = 1'b0;
    n_vec++; if ({aw_valid, w_valid, b_ready} !== 3'b001) begin n_err++;
      $display("FAIL wf_b_phase: got aw/w/b %b want 001", {aw_valid, w_valid, b_ready}); end
    b_valid = 1'b1; b_resp = RESP_SLVERR;
    step();
    b_valid = 1'b0;
    n_vec++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_lat !== 16'd5) begin n_err++;
      $display("FAIL wf_rsp: got valid %b resp %b lat %0d want 1 10 5", rsp_valid, rsp_resp, rsp_lat); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_read_decerr_hold();
    ar_ready = 1'b1;
    issue(1'b0, 32'h0000_4000, 32'h0, 4'h0);
    step();
    ar_ready = 1'b0;
    r_valid = 1'b1; r_data = 32'hCAFE_F00D; r_resp = RESP_DECERR;
    step();
    r_valid = 1'b0; r_data = '0; r_resp = RESP_OKAY;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11 || rsp_rdata !== 32'hCAFE_F00D || cmd_ready !== 1'b0) begin n_err++;
        $display("FAIL de_hold_%0d: got valid %b resp %b rdata %h ready %b want 1 11 cafef00d 0",
                 i, rsp_valid, rsp_resp, rsp_rdata, cmd_ready); end
      step();
    end
    n_vec++; if (rsp_lat !== 16'd2) begin n_err++; $display("FAIL de_lat: got %0d want 2", rsp_lat); end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_5000;
    step();
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    n_vec++; if ({rsp_valid, ar_valid, cmd_ready} !== 3'b001) begin n_err++;
      $display("FAIL de_release: got rsp_valid/ar_valid/ready %b want 001", {rsp_valid, ar_valid, cmd_ready}); end
  endtask

  task automatic test_reset_in_wr_resp();
    aw_ready = 1'b1; w_ready = 1'b1;
    issue(1'b1, 32'h0000_6000, 32'h1111_2222, 4'hF);
    step();
    aw_ready = 1'b0; w_ready = 1'b0;
    n_vec++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL rst_pre_b_ready: got %b want 1", b_ready); end
    b_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, cmd_ready} !== 7'b0) begin n_err++;
      $display("FAIL rst_async: got %b want 0000000", {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, cmd_ready}); end
    step();
    b_valid = 1'b0;
    rst_n = 1'b1;
    step();
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (rsp_valid !== 1'b0 || b_ready !== 1'b0) begin n_err++;
        $display("FAIL rst_no_rsp_%0d: got rsp_valid %b b_ready %b want 0 0", i, rsp_valid, b_ready); end
      step();
    end
  endtask

  task automatic test_back_to_back(input logic we);
    int last;
    int cnt;
    int guard;
    last = -1; cnt = 0;
    aw_ready = 1'b1; w_ready = 1'b1; ar_ready = 1'b1;
    b_valid = 1'b1; b_resp = RESP_OKAY; r_valid = 1'b1; r_data = 32'h0BAD_F00D; r_resp = RESP_OKAY;
    rsp_ready = 1'b1;
    cmd_we = we; cmd_addr = 32'h0000_7000; cmd_wdata = 32'h0; cmd_strb = 4'hF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready === 1'b1) begin
        if (last >= 0) begin
          n_vec++; if (i - last != 4) begin n_err++;
            $display("FAIL b2b_period_we%0b: got %0d cycles want 4", we, i - last); end
        end
        last = i;
        cnt++;
      end
      step();
    end
    cmd_valid = 1'b0;
    n_vec++; if (cnt != 3) begin n_err++; $display("FAIL b2b_count_we%0b: got %0d accepts want 3", we, cnt); end
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_drain_we%0b: got ready %b want 1", we, cmd_ready); end
    responder_idle();
  endtask

  task automatic test_saturation();
    ar_ready = 1'b1;
    issue(1'b0, 32'h0000_8000, 32'h0, 4'h0);
    step();
    ar_ready = 1'b0;
    repeat (70000) step();
    n_vec++; if (r_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_err++;
      $display("FAIL sat_stall: got r_ready %b rsp_valid %b want 1 0", r_ready, rsp_valid); end
    r_valid = 1'b1; r_data = 32'h0000_00AA; r_resp = RESP_OKAY;
    step();
    r_valid = 1'b0;
    n_vec++; if (rsp_valid !== 1'b1 || rsp_lat !== 16'hFFFF) begin n_err++;
      $display("FAIL sat_lat: got valid %b lat %h want 1 ffff", rsp_valid, rsp_lat); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_write_basic();
    test_read_delay();
    test_write_w_first();
    test_read_decerr_hold();
    test_reset_in_wr_resp();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
